// File: rtl/volume_level_tracker.sv
// Peak-over-window volume meter: 12-bit mic samples -> registered 0..3 level; optional decay via VOLUME_LEVEL_DECAY_EN.
// Latency: state/level_update update on the edge after the window-end strobe.
// Backpressure: none; every sample_en strobe is consumed, back-to-back strobes allowed.
module volume_level_tracker #(
    parameter int          WINDOW = 4000,
    parameter logic [11:0] TH1    = 12'd2300,
    parameter logic [11:0] TH2    = 12'd2700,
    parameter logic [11:0] TH3    = 12'd3200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [11:0] mic_in,
    output logic [2:0]  state,
    output logic        level_update,
    output logic [11:0] peak_dbg
);

    localparam logic [15:0] LAST_IDX = 16'(WINDOW - 1);

    logic [15:0] count;
    logic [11:0] peak;
    logic [11:0] peak_nxt;
    logic [1:0]  new_lvl;
    logic [2:0]  state_nxt;
    logic        win_end;

    assign win_end  = sample_en && (count == LAST_IDX);
    assign peak_nxt = (mic_in > peak) ? mic_in : peak;
    assign peak_dbg = peak;

    always_comb begin
        new_lvl = 2'd0;
        if (peak_nxt >= TH3)
            new_lvl = 2'd3;
        else if (peak_nxt >= TH2)
            new_lvl = 2'd2;
        else if (peak_nxt >= TH1)
            new_lvl = 2'd1;
    end

`ifdef VOLUME_LEVEL_DECAY_EN
    // Rises jump straight to the new level; falls step down one level per window.
    always_comb begin
        state_nxt = {1'b0, new_lvl};
        if ({1'b0, new_lvl} < state)
            state_nxt = state - 3'd1;
    end
`else
    always_comb begin
        state_nxt = {1'b0, new_lvl};
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= 16'd0;
            peak         <= 12'd0;
            state        <= 3'd0;
            level_update <= 1'b0;
        end else begin
            level_update <= 1'b0;
            if (win_end) begin
                state        <= state_nxt;
                level_update <= 1'b1;
                peak         <= 12'd0;
                count        <= 16'd0;
            end else if (sample_en) begin
                peak  <= peak_nxt;
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_volume_level_tracker.sv
// Randomized + directed bench for volume_level_tracker with a queue-based window model.
module tb_volume_level_tracker;

    localparam int W = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [11:0] mic_in;
    logic [2:0]  state;
    logic        level_update;
    logic [11:0] peak_dbg;

    volume_level_tracker #(.WINDOW(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_en    (sample_en),
        .mic_in       (mic_in),
        .state        (state),
        .level_update (level_update),
        .peak_dbg     (peak_dbg)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: samples of the open window, expected outputs.
    int win_q[$];
    int exp_state = 0;
    int exp_upd   = 0;
    int exp_peak  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int win_max();
        int m = 0;
        foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
        return m;
    endfunction

    function automatic int level_of(input int p);
        if (p >= 3200) return 3;
        if (p >= 2700) return 2;
        if (p >= 2300) return 1;
        return 0;
    endfunction

    task automatic model_step(input bit en, input int v);
        int lvl;
        exp_upd = 0;
        if (en) begin
            win_q.push_back(v);
            if (win_q.size() == W) begin
                lvl = level_of(win_max());
`ifdef VOLUME_LEVEL_DECAY_EN
                exp_state = (lvl >= exp_state) ? lvl : exp_state - 1;
`else
                exp_state = lvl;
`endif
                exp_upd = 1;
                win_q.delete();
            end
        end
        exp_peak = win_max();
    endtask

    task automatic cycle(input bit en, input int v);
        sample_en = en;
        mic_in    = v[11:0];
        @(posedge clock);
        #1;
        sample_en = 1'b0;
        model_step(en, v);
        chk("state", 16'(state), 16'(exp_state));
        chk("level_update", 16'(level_update), 16'(exp_upd));
        chk("peak_dbg", 16'(peak_dbg), 16'(exp_peak));
    endtask

    task automatic strobe_window(input int v);
        for (int i = 0; i < W; i++) cycle(1'b1, v);
    endtask

    task automatic do_reset();
        sample_en = 1'b0;
        reset     = 1'b1;
        #2;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_level_update", 16'(level_update), 16'd0);
        chk("rst_peak_dbg", 16'(peak_dbg), 16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        win_q.delete();
        exp_state = 0;
        exp_upd   = 0;
        exp_peak  = 0;
    endtask

    initial begin
        int sel;
        int v;
        reset     = 1'b0;
        sample_en = 1'b0;
        mic_in    = 12'd0;
        #1;
        do_reset();

        // Quiet window
        strobe_window(2048);
        chk("s1_state", 16'(state), 16'd0);
        chk("s1_pulse", 16'(level_update), 16'd1);
        cycle(1'b0, 0);
        chk("s1_pulse_off", 16'(level_update), 16'd0);

        // Peak on the last sample, exactly at TH2
        cycle(1'b1, 2000); cycle(1'b1, 2000); cycle(1'b1, 2000); cycle(1'b1, 2700);
        chk("s2_state", 16'(state), 16'd2);
        strobe_window(2299);
`ifdef VOLUME_LEVEL_DECAY_EN
        chk("s2_below_th1", 16'(state), 16'd1);
`else
        chk("s2_below_th1", 16'(state), 16'd0);
`endif

        // Full-scale then quiet windows
        strobe_window(4095);
        chk("s3_full", 16'(state), 16'd3);
        for (int k = 0; k < 3; k++) begin
            strobe_window(2048);
`ifdef VOLUME_LEVEL_DECAY_EN
            chk("s3_decay", 16'(state), 16'(2 - k));
`else
            chk("s3_decay", 16'(state), 16'd0);
`endif
        end

        // Irregular strobe spacing
        for (int i = 0; i < W; i++) begin
            for (int g = $urandom_range(0, 7); g > 0; g--) cycle(1'b0, $urandom_range(0, 4095));
            cycle(1'b1, (i == 1) ? 3200 : 2048);
            if (i == 1 || i == 2) chk("s4_peak_hold", 16'(peak_dbg), 16'd3200);
            if (i < W - 1) chk("s4_no_early_commit", 16'(level_update), 16'd0);
        end
        chk("s4_state", 16'(state), 16'd3);
        chk("s4_peak_cleared", 16'(peak_dbg), 16'd0);

        // Mid-window reset drops the partial window
        for (int i = 0; i < 3; i++) cycle(1'b1, 4000);
        do_reset();
        strobe_window(2048);
        chk("s5_state", 16'(state), 16'd0);

        // Continuous strobes
        strobe_window(2400);
        chk("s6_w1", 16'(state), 16'd1);
        strobe_window(2800);
        chk("s6_w2", 16'(state), 16'd2);
        strobe_window(3300);
        chk("s6_w3", 16'(state), 16'd3);

        // Random traffic around the thresholds
        for (int n = 0; n < 800; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: v = $urandom_range(0, 4095);
                1: v = 2300 + $urandom_range(0, 2) - 1;
                2: v = 2700 + $urandom_range(0, 2) - 1;
                3: v = 3200 + $urandom_range(0, 2) - 1;
                default: v = $urandom_range(1900, 2200);
            endcase
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle($urandom_range(0, 2) != 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/volume_level_tracker.md
# volume_level_tracker

Converts the 12-bit microphone sample stream into the 3-bit volume level `state` (0–3) that drives the OLED border/bar renderer directly downstream. Samples are taken on a sample-rate strobe. The peak is tracked over a fixed window of samples. At each window end the peak is quantised against three thresholds and the level output is registered, so the display updates at a steady, readable rate.

## Interface
- `WINDOW`, 4000: samples per measurement window; legal range 2–65535.
- `TH1`, 12'd2300: minimum peak for level 1.
- `TH2`, 12'd2700: minimum peak for level 2; must be greater than `TH1`.
- `TH3`, 12'd3200: minimum peak for level 3; must be greater than `TH2`.

- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sample_en` in 1: one-cycle strobe; `mic_in` is valid on cycles where it is high.
- `mic_in` in 12: unsigned mic sample; the quiet midpoint is about 2048.
- `state` out 3: registered volume level 0–3; bit 2 is always 0.
- `level_update` out 1: one-cycle pulse on the cycle after `state` is (re)written.
- `peak_dbg` out 12: current running peak; use for debug/LEDs only.

## Operation
- Registers:
  - `count`: 16 bits, range 0..WINDOW-1.
  - `peak`: 12 bits.
  - `state`: 3 bits.
  - `level_update`.
- Reset (asynchronous, any time, including mid-window):
  - `count=0`, `peak=0`, `state=0`, `level_update=0`.
  - The partial window is discarded.
- Cycles with `sample_en=0`: all registers hold, except that `level_update` returns to 0.
- Cycles with `sample_en=1` and `count<WINDOW-1`:
  - `peak <= max(peak, mic_in)`.
  - `count <= count+1`.
- Cycles with `sample_en=1` and `count==WINDOW-1` (window end):
  - `p = max(peak, mic_in)`; the last sample is included.
  - `new_lvl`:
    - 3 if `p>=TH3`;
    - else 2 if `p>=TH2`;
    - else 1 if `p>=TH1`;
    - else 0.
  - `state` is loaded per Configuration.
  - `level_update <= 1`, even if `state` is unchanged.
  - `peak <= 0`, `count <= 0`.
- Comparisons are unsigned 12-bit with inclusive thresholds, so `p==TH2` gives level 2.
- `state` never exceeds 3.
- `count` wraps only via the window-end rule; it never overflows.
- Two-state view:
  - ACCUMULATE: `count<WINDOW-1`.
  - COMMIT: the window-end strobe cycle.
  - COMMIT always returns to ACCUMULATE with `count=0`.

## Timing
- Latency:
  - `state` and `level_update` change on the first rising edge after the window-end `sample_en` cycle.
  - `level_update` is high for exactly one cycle.
- Update period: exactly `WINDOW` `sample_en` strobes, independent of the strobe spacing.
- Back-to-back strobes (`sample_en` held high) are legal: one sample is taken per cycle.
- `state` is glitch-free: it is a flop output and feeds the combinational renderer directly.
- `peak_dbg` equals `peak` (registered) and reads 0 on the cycle after a commit.

## Configuration
- Macro: `VOLUME_LEVEL_DECAY_EN`.
- Defined (peak-hold decay):
  - At COMMIT, if `new_lvl >= state`, then `state <= new_lvl`.
  - Otherwise `state <= state-1`, so the level drops by at most one per window.
- Undefined: at COMMIT, `state <= new_lvl` unconditionally.
- Rise behaviour is identical either way: the level can jump up by any amount in one window.

## Test plan
All scenarios use `WINDOW=4` and default thresholds unless noted.

1. Reset, then 4 strobes with `mic_in=2048`:
   - `state=0`.
   - `level_update` pulses once, 1 cycle after the 4th strobe.
2. Boundary check: strobes 2000, 2000, 2000, 2700, with the peak arriving on the last sample:
   - `state=2` after the 4th strobe.
   - Next window 2299 ×4 gives `state=0` with the macro undefined, and `state=1` with `VOLUME_LEVEL_DECAY_EN`.
3. Decay: a window peaking at 4095 gives `state=3`. Then three quiet windows (2048) with `VOLUME_LEVEL_DECAY_EN`:
   - `state` goes 2, 1, 0.
   - Without the macro, the first quiet window gives 0.
4. Gaps: strobes separated by 0–7 idle cycles, with 3200 at the 2nd sample:
   - Commit occurs only after the 4th strobe.
   - `state=3`.
   - `peak_dbg` reads 3200 before the commit and 0 after.
5. Mid-window reset: 3 strobes of 4000, assert `reset` for 1 cycle, then 4 strobes of 2048:
   - All outputs read 0 while `reset` is high.
   - The next commit gives `state=0`, with no carry-over of peak 4000.
6. Continuous strobes (`sample_en=1` for 12 cycles; values 2400, 2800, 3300 per window):
   - `state` becomes 1, 2, 3.
   - `level_update` pulses every 4 cycles.
